uart_rx: RTL and testbench

Oversampling UART receiver. It is the receive-side counterpart to the system's UART transmitter and uses the same frame format:
- 1 start bit (0)
- DATA_WIDTH data bits, LSB first
- optional parity bit
- 1 stop bit (1)

It synchronises the asynchronous serial line, recovers frames, checks parity and stop bit, and presents parallel data with a single-cycle valid strobe to the downstream data synchroniser / register-file logic.

---
 rtl/uart_rx.sv | 250 +++++++++++++++++++++++++
 tb/tb_uart_rx.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx
//  Description : Oversampling UART receiver. 1 start bit, DATA_WIDTH data
//                bits (LSB first), optional parity bit, 1 stop bit. The serial
//                line is double-flopped; frames are recovered with a mid-bit
//                sample and checked for parity and stop-bit errors. Results
//                appear as single-cycle strobes.
//  Options     : define UART_RX_MAJORITY_VOTE_EN to take each bit value as a
//                3-sample majority around mid-bit instead of a single sample.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx #(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 8
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  RX_IN,
    input  logic                  parity_enable,
    input  logic                  parity_type,
    output logic [DATA_WIDTH-1:0] P_DATA,
    output logic                  data_valid,
    output logic                  parity_error,
    output logic                  stop_error,
    output logic                  busy
);

    localparam int EW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    localparam logic [EW-1:0] C_EDGE_LAST = EW'(OVERSAMPLE - 1);
`ifdef UART_RX_MAJORITY_VOTE_EN
    // Vote is resolved on the last of the three samples.
    localparam logic [EW-1:0] C_DECIDE    = EW'(OVERSAMPLE / 2);
`else
    localparam logic [EW-1:0] C_DECIDE    = EW'(OVERSAMPLE / 2 - 1);
`endif
    localparam logic [BW-1:0] C_BIT_LAST  = BW'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    state_t                r_state;
    state_t                w_state_next;

    logic                  r_rx_meta;
    logic                  r_rx_s;
    logic [EW-1:0]         r_edge_cnt;
    logic [BW-1:0]         r_bit_cnt;
    logic [DATA_WIDTH-1:0] r_shift;
    logic                  r_par_en;
    logic                  r_par_type;
    logic                  r_par_bit;
    logic                  r_stop_bit;

    logic                  w_bit;
    logic                  w_sample;
    logic                  w_boundary;
    logic                  w_frame_start;
    logic                  w_abort;
    logic                  w_shift_en;
    logic                  w_bit_inc;
    logic                  w_par_latch;
    logic                  w_stop_latch;
    logic                  w_finish;
    logic                  w_par_err;
    logic                  w_stop_err;

    // Two-flop synchroniser for the asynchronous serial line (idles high).
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_meta <= 1'b1;
            r_rx_s    <= 1'b1;
        end else begin
            r_rx_meta <= RX_IN;
            r_rx_s    <= r_rx_meta;
        end
    end

`ifdef UART_RX_MAJORITY_VOTE_EN
    logic [1:0] r_rx_hist;

    // Keep the two previous synchronised samples for the majority vote.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_rx_hist <= 2'b11;
        end else begin
            r_rx_hist <= {r_rx_hist[0], r_rx_s};
        end
    end

    // Majority of samples at OVERSAMPLE/2-2, OVERSAMPLE/2-1 and OVERSAMPLE/2.
    assign w_bit = (r_rx_hist[1] & r_rx_hist[0]) |
                   (r_rx_hist[1] & r_rx_s)       |
                   (r_rx_hist[0] & r_rx_s);
`else
    assign w_bit = r_rx_s;
`endif

    assign w_sample   = (r_edge_cnt == C_DECIDE);
    assign w_boundary = (r_edge_cnt == C_EDGE_LAST);
    assign busy       = (r_state != S_IDLE);

    // Frame state register.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state logic and per-cycle datapath controls.
    always_comb begin
        w_state_next  = r_state;
        w_frame_start = 1'b0;
        w_abort       = 1'b0;
        w_shift_en    = 1'b0;
        w_bit_inc     = 1'b0;
        w_par_latch   = 1'b0;
        w_stop_latch  = 1'b0;
        w_finish      = 1'b0;
        case (r_state)
            S_IDLE: begin
                // A low line here is edge 0 of the start bit.
                if (!r_rx_s) begin
                    w_state_next  = S_START;
                    w_frame_start = 1'b1;
                end
            end
            S_START: begin
                if (w_sample && w_bit) begin
                    // Start bit did not survive to mid-bit: a glitch.
                    w_state_next = S_IDLE;
                    w_abort      = 1'b1;
                end else if (w_boundary) begin
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                w_shift_en = w_sample;
                if (w_boundary) begin
                    w_bit_inc = 1'b1;
                    if (r_bit_cnt == C_BIT_LAST) begin
                        w_state_next = r_par_en ? S_PARITY : S_STOP;
                    end
                end
            end
            S_PARITY: begin
                w_par_latch = w_sample;
                if (w_boundary) begin
                    w_state_next = S_STOP;
                end
            end
            S_STOP: begin
                w_stop_latch = w_sample;
                if (w_boundary) begin
                    w_finish     = 1'b1;
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Oversample edge counter: starts at 1 because IDLE consumed edge 0.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_edge_cnt <= '0;
        end else if (w_frame_start) begin
            r_edge_cnt <= EW'(1);
        end else if ((r_state == S_IDLE) || w_abort || w_boundary) begin
            r_edge_cnt <= '0;
        end else begin
            r_edge_cnt <= r_edge_cnt + EW'(1);
        end
    end

    // Data bit counter advanced at each data bit boundary.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_bit_cnt <= '0;
        end else if (w_frame_start) begin
            r_bit_cnt <= '0;
        end else if (w_bit_inc) begin
            r_bit_cnt <= (r_bit_cnt == C_BIT_LAST) ? '0 : r_bit_cnt + BW'(1);
        end
    end

    // Shift register, frame configuration and parity/stop bit capture.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_shift    <= '0;
            r_par_en   <= 1'b0;
            r_par_type <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_bit <= 1'b1;
        end else begin
            if (w_frame_start) begin
                // Parity settings are frozen for the whole frame.
                r_par_en   <= parity_enable;
                r_par_type <= parity_type;
            end
            if (w_shift_en) begin
                r_shift[r_bit_cnt] <= w_bit;
            end
            if (w_par_latch) begin
                r_par_bit <= w_bit;
            end
            if (w_stop_latch) begin
                r_stop_bit <= w_bit;
            end
        end
    end

    assign w_par_err  = r_par_en && (r_par_bit != ((^r_shift) ^ r_par_type));
    assign w_stop_err = !r_stop_bit;

    // Completion strobes; P_DATA only moves on a clean frame.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            P_DATA       <= '0;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            if (w_finish) begin
                parity_error <= w_par_err;
                stop_error   <= w_stop_err;
                if (!w_par_err && !w_stop_err) begin
                    data_valid <= 1'b1;
                    P_DATA     <= r_shift;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx
//  Description : Self-checking bench for uart_rx. Frames are described as bit
//                lists; the expected outcome of each frame is queued when the
//                frame is sent and a monitor compares every output pulse.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx;

    localparam int DW = 8;
    localparam int OS = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          rx_in;
    logic          pen;
    logic          ptype;
    logic [DW-1:0] p_data;
    logic          data_valid;
    logic          parity_error;
    logic          stop_error;
    logic          busy;

    typedef struct {
        logic          dv;
        logic          pe;
        logic          se;
        logic [DW-1:0] d;
        int            cyc;
    } exp_t;

    exp_t          exp_q[$];
    int            checks = 0;
    int            errors = 0;
    int            cyc = 0;
    logic [DW-1:0] last_good = '0;

    uart_rx #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .CLK          (clk),
        .RST          (rst),
        .RX_IN        (rx_in),
        .parity_enable(pen),
        .parity_type  (ptype),
        .P_DATA       (p_data),
        .data_valid   (data_valid),
        .parity_error (parity_error),
        .stop_error   (stop_error),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    // Count rising edges so expected completion times can be stated.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Send one frame starting now (1 time unit after a rising edge) and queue
    // its expected outcome. spike_bit selects a frame bit that gets a 1-cycle
    // inverted spike at mid-bit (-1 for none).
    task automatic send_frame(input logic [DW-1:0] d, input logic p_en, input logic p_type,
                              input logic pbit, input logic stopb, input bit flip_cfg,
                              input int spike_bit);
        logic bits[$];
        exp_t e;
        logic par_ok;
        int   e0;
        e0    = cyc;
        pen   = p_en;
        ptype = p_type;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(d[i]);
        if (p_en) bits.push_back(pbit);
        bits.push_back(stopb);
        par_ok = !p_en || (pbit == ((^d) ^ p_type));
        e.pe  = !par_ok;
        e.se  = !stopb;
        e.dv  = par_ok && stopb;
        if (e.dv) last_good = d;
        e.d   = last_good;
        e.cyc = e0 + 2 + bits.size() * OS;
        exp_q.push_back(e);
        for (int i = 0; i < bits.size(); i++) begin
            rx_in = bits[i];
            if (i == spike_bit) begin
                repeat (OS / 2 - 1) @(posedge clk);
                #1 rx_in = ~bits[i];
                @(posedge clk);
                #1 rx_in = bits[i];
                repeat (OS / 2) @(posedge clk);
                #1;
            end else begin
                repeat (OS) @(posedge clk);
                #1;
            end
            if (i == 0) chk("busy_in_frame", 32'(busy), 32'd1);
            if (flip_cfg && i == 3) begin
                pen   = 1'($urandom);
                ptype = 1'($urandom);
            end
        end
    endtask

    initial begin
        fork
            begin : monitor
                exp_t e;
                forever begin
                    @(negedge clk);
                    if (data_valid || parity_error || stop_error) begin
                        if (exp_q.size() == 0) begin
                            checks++;
                            errors++;
                            $display("FAIL unexpected_pulse: got dv=%0b pe=%0b se=%0b at cycle %0d, expected no pulse",
                                     data_valid, parity_error, stop_error, cyc);
                        end else begin
                            e = exp_q.pop_front();
                            chk("data_valid",   32'(data_valid),   32'(e.dv));
                            chk("parity_error", 32'(parity_error), 32'(e.pe));
                            chk("stop_error",   32'(stop_error),   32'(e.se));
                            chk("p_data",       32'(p_data),       32'(e.d));
                            chk("latency",      32'(cyc),          32'(e.cyc));
                        end
                    end
                end
            end
        join_none

        rst   = 1'b1;
        rx_in = 1'b1;
        pen   = 1'b0;
        ptype = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_p_data",       32'(p_data),       32'd0);
        chk("rst_data_valid",   32'(data_valid),   32'd0);
        chk("rst_parity_error", 32'(parity_error), 32'd0);
        chk("rst_stop_error",   32'(stop_error),   32'd0);
        chk("rst_busy",         32'(busy),         32'd0);
        rst = 1'b0;
        idle(5);

        // 8N1 0xA5
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(6);
        chk("busy_after_frame", 32'(busy), 32'd0);
        // Even parity good, then bad parity bit, then odd parity good
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(5);
        send_frame(8'h3C, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, -1);
        idle(5);
        send_frame(8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, -1);
        idle(5);
        // Stop error then a good frame
        send_frame(8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, -1);
        idle(5);
        send_frame(8'h66, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(5);
        // Start-bit glitch: two cycles low
        rx_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        idle(4 * OS);
        chk("glitch_busy",   32'(busy),   32'd0);
        chk("glitch_p_data", 32'(p_data), 32'(last_good));
        // Back-to-back frames
        send_frame(8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        send_frame(8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
        idle(10);

        // Randomised frames, including parity settings changed mid-frame
        for (int n = 0; n < 24; n++) begin
            logic [DW-1:0] d;
            logic          pe_r;
            logic          pt_r;
            logic          pb;
            logic          sb;
            d    = DW'($urandom);
            pe_r = 1'($urandom);
            pt_r = 1'($urandom);
            pb   = (^d) ^ pt_r;
            if ($urandom_range(0, 3) == 0) pb = ~pb;
            sb   = ($urandom_range(0, 4) != 0);
            send_frame(d, pe_r, pt_r, pb, sb, 1'b1, -1);
            idle($urandom_range(0, 12));
        end
        idle(10);

        // Reset during data bit 4 of 0x81
        begin
            logic [DW-1:0] d;
            d     = 8'h81;
            rx_in = 1'b0;
            pen   = 1'b0;
            repeat (OS) @(posedge clk);
            #1;
            for (int i = 0; i < 4; i++) begin
                rx_in = d[i];
                repeat (OS) @(posedge clk);
                #1;
            end
            rx_in = d[4];
            repeat (3) @(posedge clk);
            #1 rst = 1'b1;
            #1;
            chk("midrst_p_data", 32'(p_data), 32'd0);
            chk("midrst_busy",   32'(busy),   32'd0);
            chk("midrst_dv",     32'(data_valid), 32'd0);
            last_good = '0;
            rx_in     = 1'b1;
            @(posedge clk);
            #1 rst = 1'b0;
            idle(10);
            send_frame(8'h7E, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, -1);
            idle(10);
        end

`ifdef UART_RX_MAJORITY_VOTE_EN
        // Mid-bit single-cycle spikes on data bits 3 and 6
        send_frame(8'hA5, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 4);
        idle(5);
        send_frame(8'h3C, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 7);
        idle(10);
`endif

        begin
            int t;
            t = 0;
            while (exp_q.size() > 0 && t < 2000) begin
                @(posedge clk);
                t++;
            end
            #1;
            chk("queue_drained", 32'(exp_q.size()), 32'd0);
            chk("final_busy",    32'(busy),         32'd0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
